// File: rtl/sound_scheduler_if.sv
// sound_scheduler_if: request/tone bundle between the game logic and the sound scheduler
// master: drives req_paddle/req_brick/req_miss, observes audio_addr/note/tone_active/busy
// slave:  the scheduler side of the same signals
interface sound_scheduler_if;
    logic       req_paddle;
    logic       req_brick;
    logic       req_miss;
    logic [4:0] audio_addr;
    logic [1:0] note;
    logic       tone_active;
    logic       busy;
    modport master (output req_paddle, req_brick, req_miss, input audio_addr, note, tone_active, busy);
    modport slave (input req_paddle, req_brick, req_miss, output audio_addr, note, tone_active, busy);
endinterface

// File: rtl/sound_scheduler.sv
// sound_scheduler: arbitrates paddle/brick/miss sounds onto the shared sine ROM address path
// clk50mhz: system clock; reset_button: asynchronous active-low reset
// bus (slave): req_* rising-edge requests in; audio_addr, note, tone_active, busy registered out
module sound_scheduler #(
    parameter int unsigned HALF_DO    = 2986,
    parameter int unsigned HALF_RE    = 2660,
    parameter int unsigned HALF_MI    = 2369,
    parameter int unsigned HALF_SOL   = 1993,
    parameter int unsigned DUR_CYCLES = 5000000,
    parameter int unsigned GAP_CYCLES = 1000000
) (
    input  logic             clk50mhz,
    input  logic             reset_button,
    sound_scheduler_if.slave bus
);
    localparam int unsigned MAXH = HALF_DO > HALF_RE ? (HALF_DO > HALF_MI ? (HALF_DO > HALF_SOL ? HALF_DO : HALF_SOL) : (HALF_MI > HALF_SOL ? HALF_MI : HALF_SOL)) : (HALF_RE > HALF_MI ? (HALF_RE > HALF_SOL ? HALF_RE : HALF_SOL) : (HALF_MI > HALF_SOL ? HALF_MI : HALF_SOL));
    localparam int unsigned MAXT = DUR_CYCLES > GAP_CYCLES ? DUR_CYCLES : GAP_CYCLES;
    localparam int unsigned MAXP = MAXT > MAXH ? MAXT : MAXH;
    localparam int          CW   = MAXP > 1 ? $clog2(MAXP) : 1;
    typedef enum logic [1:0] {IDLE, TONE, MELODY, GAP} state_t;
    state_t        state_q;
    logic [2:0]    req_q, pend_q, req_w, rise_w, pend_w, pick_w;
    logic [CW-1:0] cnt_q, div_q, half_w;
    logic          phase_q, playing_w, wrap_w, dur_end_w, gap_end_w, restart_w;
    logic [4:0]    addr_q;
    logic [1:0]    note_q;
    always_comb begin
        req_w     = {bus.req_miss, bus.req_brick, bus.req_paddle};
        rise_w    = req_w & ~req_q;
        pend_w    = pend_q | rise_w;
        pick_w    = pend_w[2] ? 3'b100 : pend_w[1] ? 3'b010 : {2'b00, pend_w[0]};
        half_w    = note_q == 2'd0 ? CW'(HALF_DO) : note_q == 2'd1 ? CW'(HALF_RE) : note_q == 2'd2 ? CW'(HALF_MI) : CW'(HALF_SOL);
        playing_w = state_q == TONE || state_q == MELODY;
        wrap_w    = div_q == half_w - CW'(1);
        dur_end_w = cnt_q == CW'(DUR_CYCLES - 1);
        gap_end_w = cnt_q == CW'(GAP_CYCLES - 1);
        // every state change except none restarts divider, phase, address and cycle counter
        restart_w = state_q == IDLE ? |pend_w : state_q == GAP ? gap_end_w : dur_end_w || (state_q == TONE && rise_w[2]);
    end
    always_ff @(posedge clk50mhz or negedge reset_button) begin
        if (!reset_button) begin
            state_q         <= IDLE;
            req_q           <= '0;
            pend_q          <= '0;
            cnt_q           <= '0;
            div_q           <= '0;
            phase_q         <= 1'b0;
            addr_q          <= '0;
            note_q          <= '0;
            bus.audio_addr  <= '0;
            bus.note        <= '0;
            bus.tone_active <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            req_q           <= req_w;
            pend_q          <= pend_w;
            bus.audio_addr  <= addr_q;
            bus.note        <= note_q;
            bus.tone_active <= playing_w;
            bus.busy        <= state_q != IDLE;
            if (playing_w) begin
                cnt_q   <= cnt_q + CW'(1);
                div_q   <= wrap_w ? '0 : div_q + CW'(1);
                phase_q <= phase_q ^ wrap_w;
                // address advances once per full 2*HALF period, on the high-to-low phase wrap
                addr_q  <= addr_q + 5'(wrap_w & phase_q);
            end
            case (state_q)
                IDLE: if (|pend_w) begin
                    state_q <= pick_w[2] ? MELODY : TONE;
                    note_q  <= pick_w[2] ? 2'd3 : pick_w[1] ? 2'd1 : 2'd0;
                    pend_q  <= pend_w & ~pick_w;
                end
                TONE: if (rise_w[2]) begin
                    state_q <= MELODY;
                    note_q  <= 2'd3;
                    pend_q  <= {1'b0, pend_w[1:0]};
                end else if (dur_end_w) begin
                    state_q <= GAP;
                end
                MELODY: begin
                    // a miss during its own melody is dropped rather than queued
                    pend_q <= {pend_q[2], pend_w[1:0]};
                    if (dur_end_w) begin
                        if (note_q == 2'd0) state_q <= GAP;
                        else note_q <= note_q - 2'd1;
                    end
                end
                GAP: if (gap_end_w) state_q <= IDLE;
                     else cnt_q <= cnt_q + CW'(1);
            endcase
            if (restart_w) begin
                cnt_q   <= '0;
                div_q   <= '0;
                phase_q <= 1'b0;
                addr_q  <= '0;
            end
        end
    end
endmodule
